serial_rx: RTL and testbench

Receiver for the serial frames that the control top drives on out_fin. It sits directly downstream of that output on a loopback or bench path. It oversamples the line on sysclk, deserializes each frame and presents the recovered byte with a one-cycle strobe. It also counts good frames and flags framing errors, so the byte stream from the ROM/splitter path can be checked in hardware.

---
 rtl/serial_pkg.sv | 17 +
 rtl/sync_ff.sv | 24 ++
 rtl/serial_rx.sv | 122 ++++++++++++
 tb/tb_serial_rx.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/serial_pkg.sv
// Shared serial-frame definitions for the receiver and transmitter sides.
// Frame is start bit, DATA_BITS data bits LSB first, stop bit, no parity.
package serial_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } rx_state_e;

  localparam int   DATA_BITS   = 8;
  localparam logic START_LEVEL = 1'b0;
  localparam logic STOP_LEVEL  = 1'b1;

endpackage

// File: rtl/sync_ff.sv
// STAGES-deep synchroniser for an asynchronous level; all flops reset to 1.
// Latency STAGES cycles, no handshake.
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/serial_rx.sv
// Oversampling serial receiver: strobes valid/frame_err SYNC_STAGES + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT + 1
// cycles after the start-bit falling edge; no backpressure, a byte not consumed on the strobe is overwritten.
module serial_rx
  import serial_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int SYNC_STAGES  = 2
) (
  input  logic       sysclk,
  input  logic       reset,
  input  logic       rx_in,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err,
  output logic       busy,
  output logic [7:0] rx_count
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS);
  localparam logic [TW-1:0] HALF_M1  = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] FULL_M1  = TW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] LAST_BIT = IW'(DATA_BITS - 1);

  logic                 rx_s;
  rx_state_e            state_q;
  logic [TW-1:0]        timer_q;
  logic [IW-1:0]        bit_idx_q;
  logic [DATA_BITS-1:0] shift_q;
  logic [DATA_BITS-1:0] shift_d;
  logic [7:0]           data_q;
  logic                 valid_q;
  logic                 frame_err_q;
  logic [7:0]           rx_count_q;
  logic [7:0]           rx_count_d;

  sync_ff #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk_i  (sysclk),
    .reset_i(reset),
    .d_i    (rx_in),
    .q_o    (rx_s)
  );

  // LSB arrives first, so new bits enter at the top and shift down.
  assign shift_d    = {rx_s, shift_q[DATA_BITS-1:1]};
  assign rx_count_d = rx_count_q + 8'd1;

  always_ff @(posedge sysclk) begin
    if (reset) begin
      state_q     <= IDLE;
      timer_q     <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      rx_count_q  <= '0;
    end else begin
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          timer_q <= '0;
          if (rx_s == START_LEVEL) state_q <= START;
        end
        START: begin
          if (timer_q == HALF_M1) begin
            timer_q   <= '0;
            bit_idx_q <= '0;
            state_q   <= (rx_s == START_LEVEL) ? DATA : IDLE;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        DATA: begin
          if (timer_q == FULL_M1) begin
            timer_q   <= '0;
            shift_q   <= shift_d;
            bit_idx_q <= bit_idx_q + 1'b1;
            if (bit_idx_q == LAST_BIT) state_q <= STOP;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        STOP: begin
          if (timer_q == FULL_M1) begin
            timer_q <= '0;
            if (rx_s == STOP_LEVEL) begin
              data_q     <= shift_q;
              valid_q    <= 1'b1;
              rx_count_q <= rx_count_d;
              state_q    <= IDLE;
            end else begin
              frame_err_q <= 1'b1;
              state_q     <= WAIT_IDLE;
            end
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        WAIT_IDLE: begin
          // A held-low line must release before another start bit is accepted.
          timer_q <= '0;
          if (rx_s == STOP_LEVEL) state_q <= IDLE;
        end
        default: begin
          timer_q <= '0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign data      = data_q;
  assign valid     = valid_q;
  assign frame_err = frame_err_q;
  assign busy      = (state_q != IDLE);
  assign rx_count  = rx_count_q;

endmodule

// File: tb/tb_serial_rx.sv
// Directed + random frame bench for serial_rx with a queue-based reference model.
module tb_serial_rx;

  localparam int N    = 16;
  localparam int SYNC = 2;
  localparam int L    = SYNC + N / 2 + 9 * N + 1;

  logic       sysclk = 1'b0;
  logic       reset  = 1'b1;
  logic       rx_in  = 1'b1;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       busy;
  logic [7:0] rx_count;

  serial_rx #(
    .CLKS_PER_BIT(N),
    .SYNC_STAGES (SYNC)
  ) dut (
    .sysclk   (sysclk),
    .reset    (reset),
    .rx_in    (rx_in),
    .data     (data),
    .valid    (valid),
    .frame_err(frame_err),
    .busy     (busy),
    .rx_count (rx_count)
  );

  always #5 sysclk = ~sysclk;

  int cyc = 0;
  always @(posedge sysclk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  logic [7:0] obs_q[$];
  int         obs_t[$];
  logic       obs_busy[$];
  int         err_t[$];
  int         both_n = 0;

  logic [7:0] exp_q[$];
  int         exp_t[$];
  int         good_n = 0;
  logic [7:0] last_good = 8'h00;
  int         last_t0 = 0;

  always @(negedge sysclk) begin
    if (valid === 1'b1) begin
      obs_q.push_back(data);
      obs_t.push_back(cyc);
      obs_busy.push_back(busy);
    end
    if (frame_err === 1'b1) err_t.push_back(cyc);
    if (valid === 1'b1 && frame_err === 1'b1) both_n++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic chk_lat(input string tag, input int lat);
    checks++;
    assert (lat >= L - 1 && lat <= L + 1) else begin
      errors++;
      $error("FAIL %s: got latency %0d expected %0d +/-1", tag, lat, L);
    end
  endtask

  task automatic drive_bit(input logic lvl, input int cycles);
    @(negedge sysclk);
    rx_in = lvl;
    repeat (cycles - 1) @(negedge sysclk);
  endtask

  task automatic idle(input int cycles);
    drive_bit(1'b1, cycles);
  endtask

  // Line bits: start(0), data LSB first, stop; good frames enter the model.
  task automatic send_frame(input logic [7:0] b, input logic stop_lvl, input bit good);
    logic [9:0] bits;
    bits = {stop_lvl, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      @(negedge sysclk);
      rx_in = bits[i];
      if (i == 0) last_t0 = cyc;
      repeat (N - 1) @(negedge sysclk);
    end
    if (good) begin
      exp_q.push_back(b);
      exp_t.push_back(last_t0);
      good_n++;
      last_good = b;
    end
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 4 * N && obs_q.size() < exp_q.size(); i++) @(negedge sysclk);
    chk({tag, "_frames"}, obs_q.size(), exp_q.size());
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      logic [7:0] eb, ob;
      int et, ot;
      logic bz;
      eb = exp_q.pop_front();
      et = exp_t.pop_front();
      ob = obs_q.pop_front();
      ot = obs_t.pop_front();
      bz = obs_busy.pop_front();
      chk({tag, "_data"}, ob, eb);
      chk_lat({tag, "_lat"}, ot - et);
      chk({tag, "_busy_at_valid"}, bz, 1'b0);
    end
    exp_q.delete(); exp_t.delete();
    obs_q.delete(); obs_t.delete(); obs_busy.delete();
  endtask

  initial begin
    logic [7:0] r;
    int errlat;

    // Reset and idle line
    repeat (4) @(negedge sysclk);
    reset = 1'b0;
    @(negedge sysclk);
    chk("reset_data", data, 8'h00);
    chk("reset_valid", valid, 1'b0);
    chk("reset_frame_err", frame_err, 1'b0);
    chk("reset_busy", busy, 1'b0);
    chk("reset_count", rx_count, 8'h00);
    idle(10 * N);
    chk("idle_no_valid", obs_q.size(), 0);
    chk("idle_busy", busy, 1'b0);

    // Single 0xA5
    send_frame(8'hA5, 1'b1, 1'b1);
    drain("a5");
    chk("a5_data_out", data, 8'hA5);
    chk("a5_count", rx_count, 8'(good_n));

    // Back-to-back, directed then random
    send_frame(8'h00, 1'b1, 1'b1);
    send_frame(8'hFF, 1'b1, 1'b1);
    send_frame(8'h55, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      r = 8'($urandom);
      send_frame(r, 1'b1, 1'b1);
    end
    drain("b2b");
    chk("b2b_count", rx_count, 8'(good_n));

    // Start glitch
    idle(N);
    drive_bit(1'b0, 4);
    idle(3 * N);
    chk("glitch_no_valid", obs_q.size(), 0);
    chk("glitch_no_err", err_t.size(), 0);
    chk("glitch_busy", busy, 1'b0);
    send_frame(8'h3C, 1'b1, 1'b1);
    drain("after_glitch");
    chk("after_glitch_data", data, 8'h3C);

    // Break: stop bit low, line held low, then released
    send_frame(8'h81, 1'b0, 1'b0);
    drive_bit(1'b0, 40);
    idle(2 * N);
    chk("break_err_count", err_t.size(), 1);
    errlat = (err_t.size() > 0) ? err_t[0] - last_t0 : -1;
    chk_lat("break_err_lat", errlat);
    chk("break_no_valid", obs_q.size(), 0);
    chk("break_data_held", data, last_good);
    chk("break_count_held", rx_count, 8'(good_n));
    chk("break_busy", busy, 1'b0);
    err_t.delete();
    send_frame(8'h42, 1'b1, 1'b1);
    drain("after_break");
    chk("after_break_data", data, 8'h42);
    chk("after_break_count", rx_count, 8'(good_n));

    // Reset in the middle of data bit 3 (bit 3 forced high so the line is idle-level)
    r = 8'($urandom) | 8'h08;
    drive_bit(1'b0, N);
    for (int i = 0; i < 3; i++) drive_bit(r[i], N);
    drive_bit(r[3], N / 2);
    @(negedge sysclk);
    reset = 1'b1;
    rx_in = 1'b1;
    @(negedge sysclk);
    reset = 1'b0;
    good_n = 0;
    last_good = 8'h00;
    idle(12 * N);
    chk("abort_no_valid", obs_q.size(), 0);
    chk("abort_no_err", err_t.size(), 0);
    chk("abort_data", data, 8'h00);
    chk("abort_count", rx_count, 8'h00);
    chk("abort_busy", busy, 1'b0);
    send_frame(8'h7E, 1'b1, 1'b1);
    drain("7e");
    chk("7e_count", rx_count, 8'(good_n));

    // 256 further random frames: counter wraps
    for (int i = 0; i < 256; i++) begin
      r = 8'($urandom);
      send_frame(r, 1'b1, 1'b1);
      if ((i % 32) == 31) drain("bulk");
    end
    drain("bulk_tail");
    chk("wrap_count", rx_count, 8'(good_n));
    chk("wrap_data", data, last_good);
    chk("no_valid_with_err", both_n, 0);
    chk("no_stray_err", err_t.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
